// File: rtl/instr_encoder.sv
// instr_encoder -- two-stage RV32 instruction word encoder.
//
// Takes the individual fields of one instruction plus a full-width immediate
// and produces the packed 32-bit RV32 encoding for the selected format
// (I, U, S, B, J, R). Optionally checks that the immediate fits and is
// aligned for the format, and reports bad formats unconditionally.
//
// Pipeline:
//   S1 registers the request fields; the error check and the word assembly
//        are computed combinationally from those registers.
//   S2 registers the assembled word / error and holds it until accepted.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   in_valid/in_ready request handshake
//   fmt               000 I, 001 U, 010 S, 011 B, 100 J, 101 R, 11x invalid
//   opcode, rd, rs1, rs2, funct3, funct7, imm   instruction fields
//   out_valid/out_ready result handshake
//   instr             encoded word (zero on any error)
//   err, err_code     error flag / code (00 none, 01 range, 10 misaligned,
//                     11 bad fmt), qualified by out_valid
//   err_count         saturating count of errored results taken downstream
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. A producer holding valid keeps its payload stable until the
// transfer; ready may depend combinationally on the consumer's ready.
// Here in_ready = !s1_valid || out-stage-can-load, and the output payload is
// frozen while out_valid=1 and out_ready=0.

module instr_encoder #(
    parameter int unsigned CHECK_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [7:0]  err_count
);

    localparam logic [2:0] FMT_I = 3'b000;
    localparam logic [2:0] FMT_U = 3'b001;
    localparam logic [2:0] FMT_S = 3'b010;
    localparam logic [2:0] FMT_B = 3'b011;
    localparam logic [2:0] FMT_J = 3'b100;
    localparam logic [2:0] FMT_R = 3'b101;

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_RANGE = 2'b01;
    localparam logic [1:0] CODE_ALIGN = 2'b10;
    localparam logic [1:0] CODE_FMT   = 2'b11;

    localparam logic CHECK_ON = (CHECK_EN != 0);

    // S1 registers
    logic        s1_valid_q,  s1_valid_d;
    logic [2:0]  s1_fmt_q;
    logic [6:0]  s1_opcode_q;
    logic [4:0]  s1_rd_q;
    logic [4:0]  s1_rs1_q;
    logic [4:0]  s1_rs2_q;
    logic [2:0]  s1_funct3_q;
    logic [6:0]  s1_funct7_q;
    logic [31:0] s1_imm_q;

    // S2 registers
    logic        out_valid_q;
    logic [31:0] instr_q,     instr_d;
    logic        err_q,       err_d;
    logic [1:0]  err_code_q,  err_code_d;
    logic [7:0]  err_count_q, err_count_d;

    logic s2_load;
    logic accept;
    logic range_err;
    logic align_err;
    logic fmt_err;
    logic [31:0] word;

    // S2 can take a new value when it is empty or its result leaves this
    // cycle; S1 drains into S2 under exactly the same condition.
    assign s2_load  = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_load;
    assign accept   = in_valid && in_ready;

    // S1 stays occupied only if it holds a request that could not move on.
    assign s1_valid_d = accept ? 1'b1 : (s2_load ? 1'b0 : s1_valid_q);

    // Immediate checks on the registered S1 fields. "Not all equal" over the
    // upper bits means the value does not sign-extend from the field width.
    always_comb begin
        range_err = 1'b0;
        align_err = 1'b0;
        case (s1_fmt_q)
            FMT_I, FMT_S: range_err = !((&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]));
            FMT_B: begin
                range_err = !((&s1_imm_q[31:12]) || !(|s1_imm_q[31:12]));
                align_err = s1_imm_q[0];
            end
            FMT_J: begin
                range_err = !((&s1_imm_q[31:20]) || !(|s1_imm_q[31:20]));
                align_err = s1_imm_q[0];
            end
            FMT_U:   range_err = (s1_imm_q[11:0] != 12'd0);
            default: range_err = 1'b0;
        endcase
    end

    assign fmt_err = s1_fmt_q[2] & s1_fmt_q[1];

    // Field packing per format (MSB to LSB).
    always_comb begin
        word = 32'd0;
        case (s1_fmt_q)
            FMT_I: word = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
            FMT_S: word = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                           s1_imm_q[4:0], s1_opcode_q};
            FMT_B: word = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                           s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
            FMT_U: word = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
            FMT_J: word = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                           s1_rd_q, s1_opcode_q};
            FMT_R: word = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
            default: word = 32'd0;
        endcase
    end

    // Error priority: bad fmt, then misaligned, then range.
    always_comb begin
        err_code_d = CODE_NONE;
        if (fmt_err) begin
            err_code_d = CODE_FMT;
        end else if (CHECK_ON && align_err) begin
            err_code_d = CODE_ALIGN;
        end else if (CHECK_ON && range_err) begin
            err_code_d = CODE_RANGE;
        end
        err_d   = (err_code_d != CODE_NONE);
        instr_d = err_d ? 32'd0 : word;
    end

    always_comb begin
        err_count_d = err_count_q;
        if (out_valid_q && out_ready && err_q && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // S1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_fmt_q    <= 3'd0;
            s1_opcode_q <= 7'd0;
            s1_rd_q     <= 5'd0;
            s1_rs1_q    <= 5'd0;
            s1_rs2_q    <= 5'd0;
            s1_funct3_q <= 3'd0;
            s1_funct7_q <= 7'd0;
            s1_imm_q    <= 32'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (accept) begin
                s1_fmt_q    <= fmt;
                s1_opcode_q <= opcode;
                s1_rd_q     <= rd;
                s1_rs1_q    <= rs1;
                s1_rs2_q    <= rs2;
                s1_funct3_q <= funct3;
                s1_funct7_q <= funct7;
                s1_imm_q    <= imm;
            end
        end
    end

    // S2: payload only changes when a real request moves in, so a bubble
    // leaves the last result visible but unqualified.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            instr_q     <= 32'd0;
            err_q       <= 1'b0;
            err_code_q  <= CODE_NONE;
            err_count_q <= 8'd0;
        end else begin
            err_count_q <= err_count_d;
            if (s2_load) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    instr_q    <= instr_d;
                    err_q      <= err_d;
                    err_code_q <= err_code_d;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign instr     = instr_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign err_count = err_count_q;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter CHECK_EN, default 1: 1 enables immediate range and alignment checks; 0 disables them and truncates immediates silently.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL have port fmt  input  3  format: 000 I, 001 U, 010 S, 011 B, 100 J, 101 R, 110/111 invalid.
REQ-007 SHALL have ports opcode  input  7; rd, rs1, rs2  input  5 each; funct3  input  3; funct7  input  7. These are the instruction fields.
REQ-008 SHALL have port imm  input  32  full-width two's-complement immediate; byte offset for B/J; full value for U.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts result.
REQ-011 SHALL have port instr  output  32  encoded RV32 instruction word.
REQ-012 SHALL have ports err  output  1  and err_code  output  2  (00 none, 01 range, 10 misaligned, 11 bad fmt), both valid with out_valid.
REQ-013 SHALL have port err_count  output  8  saturating count of errored results accepted downstream.

Function
REQ-014 SHALL accept a request on a clock edge where in_valid and in_ready are both 1; SHALL ignore all inputs otherwise.
REQ-015 SHALL be a 2-stage pipeline. S1 registers the fields and computes the check. S2 assembles and holds the output.
REQ-016 SHALL assert out_valid on the 2nd rising edge after acceptance when there is no backpressure. Throughput SHALL be 1 request per cycle.
REQ-017 in_ready SHALL be combinational: in_ready = !s1_valid or (S1 advances this cycle). S1 advances when S2 is empty or out_ready=1.
REQ-018 While out_valid=1 and out_ready=0, instr, err, err_code SHALL hold stable and no stage SHALL advance.
REQ-019 SHALL never drop, duplicate, or reorder requests.
REQ-020 I format: instr = imm[11:0], rs1, funct3, rd, opcode (MSB to LSB).
REQ-021 S format: instr = imm[11:5], rs2, rs1, funct3, imm[4:0], opcode.
REQ-022 B format: instr = imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode.
REQ-023 U format: instr = imm[31:12], rd, opcode.
REQ-024 J format: instr = imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode.
REQ-025 R format: instr = funct7, rs2, rs1, funct3, rd, opcode; imm ignored.
REQ-026 With CHECK_EN=1, the range error SHALL apply as follows:
- I/S: imm[31:11] not all equal.
- B: imm[31:12] not all equal.
- J: imm[31:20] not all equal.
- U: imm[11:0] != 0.
REQ-027 With CHECK_EN=1, the misaligned error SHALL apply for B/J when imm[0]=1.
REQ-028 A bad-fmt error SHALL apply for fmt 110/111 regardless of CHECK_EN.
REQ-029 Error priority SHALL be: bad fmt > misaligned > range.
REQ-030 On any error, instr SHALL be 32'h0000_0000 and err SHALL be 1.
REQ-031 err_count SHALL increment on each out_valid and out_ready handshake with err=1, and saturate at 255.

Reset
REQ-032 On rst=1, immediately and asynchronously, the block SHALL clear:
- s1_valid, out_valid, err, err_count → 0;
- instr → 0; err_code → 00.
REQ-033 Reset mid-operation SHALL discard all in-flight requests. in_ready SHALL be 1 on the first cycle after rst deasserts.

Verification
REQ-034 Bench SHALL cover: I case, fmt=000, opcode=0010011, rd=1, rs1=0, funct3=0, imm=5 → instr=0x00500093, err=0, out_valid 2 cycles after accept.
REQ-035 Bench SHALL cover: B case, fmt=011, opcode=1100011, rs1=1, rs2=2, funct3=0, imm=0xFFFFFFFC → instr=0xFE208EE3.
REQ-036 Bench SHALL cover: U case, fmt=001, opcode=0110111, rd=5, imm=0x12345000 → instr=0x123452B7; then imm=0x12345001 → err=1, err_code=01, instr=0.
REQ-037 Bench SHALL cover error cases:
- fmt=000, imm=2048 → err_code=01.
- fmt=100, imm=3 → err_code=10.
- fmt=111 → err_code=11.
- err_count SHALL read 3 after all three are accepted.
REQ-038 Bench SHALL cover backpressure: 4 back-to-back requests with out_ready=0 for 4 cycles → in_ready=0 once both stages are full, instr stable, all 4 results emerge in order once out_ready=1.
REQ-039 Bench SHALL cover reset mid-operation: assert rst with both stages full → out_valid=0 in the same cycle, err_count=0, no stale result after release.
